id_ex_operand_stage: RTL and testbench

Pipeline register and operand-forwarding stage that sits directly upstream of the ALU. It captures the decoded instruction from the decode stage on each clock edge and drives the ALU `A`, `B` and `ALU_Control` inputs. Before driving them it resolves read-after-write hazards against the EX/MEM and MEM/WB results. It also supports stall (hold), flush (bubble insertion) and a saturating bubble counter for performance monitoring.

---
 rtl/id_ex_operand_stage.sv | 129 ++++++++++++
 tb/tb_id_ex_operand_stage.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with RAW operand forwarding from EX/MEM and MEM/WB.
// Latency: 1 cycle from id_* to the stage registers; forwarding muxes are combinational.
// Backpressure: stall holds every stage register, and flush (or reset) loads a bubble.
module id_ex_operand_stage #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [2:0]       id_alu_control,
  input  logic             id_alu_src,
  input  logic             id_reg_dst,
  input  logic             id_reg_write,
  input  logic             mem_reg_write,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic [WIDTH-1:0] mem_result,
  input  logic             wb_reg_write,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic [WIDTH-1:0] wb_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic [RA_W-1:0]  ex_dest,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  logic             valid_q;
  logic [RA_W-1:0]  rs_q;
  logic [RA_W-1:0]  rt_q;
  logic [RA_W-1:0]  dest_q;
  logic [WIDTH-1:0] rs_data_q;
  logic [WIDTH-1:0] rt_data_q;
  logic [WIDTH-1:0] imm_q;
  logic [2:0]       alu_control_q;
  logic             alu_src_q;
  logic             reg_write_q;
  logic [WIDTH-1:0] fwd_rs;
  logic [WIDTH-1:0] fwd_rt;

  // Stage register: reset/flush load a bubble, stall holds, otherwise capture decode.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q       <= 1'b0;
      rs_q          <= '0;
      rt_q          <= '0;
      dest_q        <= '0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      imm_q         <= '0;
      alu_control_q <= 3'b000;
      alu_src_q     <= 1'b0;
      reg_write_q   <= 1'b0;
    end else if (!stall) begin
      valid_q       <= id_valid;
      rs_q          <= id_rs;
      rt_q          <= id_rt;
      dest_q        <= id_reg_dst ? id_rd : id_rt;
      rs_data_q     <= id_rs_data;
      rt_data_q     <= id_rt_data;
      imm_q         <= id_imm;
      alu_control_q <= id_alu_control;
      alu_src_q     <= id_alu_src;
      reg_write_q   <= id_reg_write & id_valid;
    end
  end

  // Saturating count of edges that leave an empty stage; keeps running through stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_count <= '0;
    end else if (!valid_q && (bubble_count != {CNT_W{1'b1}})) begin
      bubble_count <= bubble_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Operand forwarding: the younger MEM result beats WB, and r0 is never forwarded.
  always_comb begin
    fwd_a_sel = SEL_RF;
    fwd_rs    = rs_data_q;
    if (mem_reg_write && (mem_rd == rs_q) && (rs_q != '0)) begin
      fwd_a_sel = SEL_MEM;
      fwd_rs    = mem_result;
    end else if (wb_reg_write && (wb_rd == rs_q) && (rs_q != '0)) begin
      fwd_a_sel = SEL_WB;
      fwd_rs    = wb_result;
    end

    fwd_b_sel = SEL_RF;
    fwd_rt    = rt_data_q;
    if (mem_reg_write && (mem_rd == rt_q) && (rt_q != '0)) begin
      fwd_b_sel = SEL_MEM;
      fwd_rt    = mem_result;
    end else if (wb_reg_write && (wb_rd == rt_q) && (rt_q != '0)) begin
      fwd_b_sel = SEL_WB;
      fwd_rt    = wb_result;
    end
  end

  // Output drive: the immediate replaces only the B operand, so store data always carries rt.
  always_comb begin
    alu_a         = fwd_rs;
    alu_b         = alu_src_q ? imm_q : fwd_rt;
    ex_store_data = fwd_rt;
    alu_control   = alu_control_q;
    ex_valid      = valid_q;
    ex_reg_write  = reg_write_q;
    ex_dest       = dest_q;
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;
  localparam int WIDTH = 32;
  localparam int RA_W  = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset, stall, flush;
  logic             id_valid;
  logic [RA_W-1:0]  id_rs, id_rt, id_rd;
  logic [WIDTH-1:0] id_rs_data, id_rt_data, id_imm;
  logic [2:0]       id_alu_control;
  logic             id_alu_src, id_reg_dst, id_reg_write;
  logic             mem_reg_write, wb_reg_write;
  logic [RA_W-1:0]  mem_rd, wb_rd;
  logic [WIDTH-1:0] mem_result, wb_result;
  logic [WIDTH-1:0] alu_a, alu_b, ex_store_data;
  logic [2:0]       alu_control;
  logic             ex_valid, ex_reg_write;
  logic [RA_W-1:0]  ex_dest;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] bubble_count;

  int tests = 0;
  int fails = 0;

  id_ex_operand_stage #(.WIDTH(WIDTH), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_dest(ex_dest),
    .ex_store_data(ex_store_data), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic v, input logic [4:0] rs, input logic [31:0] rsd,
                      input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd,
                      input logic [31:0] imm, input logic [2:0] ctl, input logic src,
                      input logic dst, input logic wr);
    id_valid = v; id_rs = rs; id_rs_data = rsd; id_rt = rt; id_rt_data = rtd;
    id_rd = rd; id_imm = imm; id_alu_control = ctl; id_alu_src = src;
    id_reg_dst = dst; id_reg_write = wr;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    mem_reg_write = 1'b0; mem_rd = '0; mem_result = '0;
    wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0;
    load(1'($urandom), 5'($urandom), $urandom, 5'($urandom), $urandom, 5'($urandom),
         $urandom, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    #1;
    tick();
    load(1'($urandom), 5'($urandom), $urandom, 5'($urandom), $urandom, 5'($urandom),
         $urandom, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    tick();
    chk("rst_valid", 32'(ex_valid), 0);
    chk("rst_regwr", 32'(ex_reg_write), 0);
    chk("rst_ctl", 32'(alu_control), 0);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_store", ex_store_data, 0);
    chk("rst_dest", 32'(ex_dest), 0);
    chk("rst_sel", {28'd0, fwd_a_sel, fwd_b_sel}, 0);
    chk("rst_bubble", 32'(bubble_count), 0);

    // Plain SUB load: first edge after reset sees an empty stage, so one bubble counted.
    reset = 1'b0;
    load(1, 5'd1, 32'd10, 5'd2, 32'd5, 5'd7, 32'd0, 3'b110, 0, 1, 1);
    tick();
    chk("load_a", alu_a, 10);
    chk("load_b", alu_b, 5);
    chk("load_ctl", 32'(alu_control), 32'h6);
    chk("load_sel", {28'd0, fwd_a_sel, fwd_b_sel}, 0);
    chk("load_valid", 32'(ex_valid), 1);
    chk("load_regwr", 32'(ex_reg_write), 1);
    chk("load_dest", 32'(ex_dest), 7);
    chk("load_store", ex_store_data, 5);
    chk("load_bubble", 32'(bubble_count), 1);

    // Forward priority on rs=3.
    load(1, 5'd3, 32'd1, 5'd4, 32'd2, 5'd9, 32'd0, 3'b010, 0, 1, 1);
    tick();
    mem_reg_write = 1; mem_rd = 5'd3; mem_result = 32'd77;
    wb_reg_write = 1; wb_rd = 5'd3; wb_result = 32'd55;
    #1;
    chk("fwd_mem_a", alu_a, 77);
    chk("fwd_mem_sel", 32'(fwd_a_sel), 2);
    chk("fwd_b_none", alu_b, 2);
    chk("fwd_b_none_sel", 32'(fwd_b_sel), 0);
    mem_reg_write = 0;
    #1;
    chk("fwd_wb_a", alu_a, 55);
    chk("fwd_wb_sel", 32'(fwd_a_sel), 1);

    // r0 never forwarded; immediate on B while store data carries forwarded rt.
    load(1, 5'd0, 32'd123, 5'd5, 32'd9, 5'd20, 32'hFFFF_FFFF, 3'b001, 1, 0, 1);
    tick();
    mem_reg_write = 1; mem_rd = 5'd0; mem_result = 32'd99;
    wb_reg_write = 1; wb_rd = 5'd5; wb_result = 32'd42;
    #1;
    chk("r0_a", alu_a, 123);
    chk("r0_sel", 32'(fwd_a_sel), 0);
    chk("imm_b", alu_b, 32'hFFFF_FFFF);
    chk("imm_store", ex_store_data, 42);
    chk("imm_bsel", 32'(fwd_b_sel), 1);
    chk("rt_dest", 32'(ex_dest), 5);
    mem_reg_write = 0; wb_reg_write = 0; mem_rd = '0; wb_rd = '0;

    // Load ADD, then stall 3 cycles with different decode inputs.
    load(1, 5'd6, 32'd100, 5'd7, 32'd200, 5'd8, 32'd0, 3'b010, 0, 1, 1);
    tick();
    chk("add_a", alu_a, 100);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      load(0, 5'd11, 32'hDEAD, 5'd12, 32'hBEEF, 5'd13, 32'h1, 3'b111, 1, 0, 0);
      tick();
      chk("stall_a", alu_a, 100);
      chk("stall_b", alu_b, 200);
      chk("stall_ctl", 32'(alu_control), 2);
      chk("stall_valid", 32'(ex_valid), 1);
      chk("stall_dest", 32'(ex_dest), 8);
    end
    wb_reg_write = 1; wb_rd = 5'd6; wb_result = 32'h1234;
    #1;
    chk("stall_fwd_a", alu_a, 32'h1234);
    wb_reg_write = 0; wb_rd = '0;
    flush = 1;
    tick();
    chk("flush_valid", 32'(ex_valid), 0);
    chk("flush_regwr", 32'(ex_reg_write), 0);
    chk("flush_ctl", 32'(alu_control), 0);
    chk("flush_a", alu_a, 0);
    chk("flush_dest", 32'(ex_dest), 0);

    // Reset during stall, then saturating bubble count (stall held for the first cycles).
    flush = 0;
    load(1, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3, 32'd0, 3'b010, 0, 1, 1);
    reset = 1;
    tick();
    chk("rst_stall_valid", 32'(ex_valid), 0);
    chk("rst_stall_bubble", 32'(bubble_count), 0);
    reset = 0;
    id_valid = 0;
    for (int i = 1; i <= 20; i++) begin
      stall = (i <= 5);
      tick();
      chk("bubble_cnt", 32'(bubble_count), (i > 15) ? 32'd15 : 32'(i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
